// File: rtl/irq_controller.sv
// Prioritising interrupt controller: edge-latched pending sources, fixed priority
// (index 0 highest), single outstanding request to the CPU with a one-cycle HOLD gap.
module irq_controller #(
  parameter int          NUM_SRC     = 8,
  parameter logic [31:0] VECTOR_BASE = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irqLines,
  input  logic               cfgWE,
  input  logic [1:0]         cfgAddr,
  input  logic [15:0]        cfgData,
  output logic [15:0]        cfgRead,
  output logic               irq,
  input  logic               turnOffIRQ,
  output logic [31:0]        intAddr,
  output logic [15:0]        intData
);

  localparam logic [15:0] SRC_MASK = 16'((32'd1 << NUM_SRC) - 32'd1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

  state_t      r_state;
  logic [15:0] r_prev;
  logic [15:0] r_pend;
  logic [15:0] r_mask;
  logic        r_gie;
  logic        r_armed;
  logic [3:0]  r_idx;
  logic        r_irq;
  logic [31:0] r_intAddr;

  logic [15:0] w_lines;
  logic [15:0] w_pendSet;
  logic [15:0] w_ackClr;
  logic [15:0] w_w1c;
  logic [15:0] w_pendNext;
  logic [15:0] w_elig;
  logic [3:0]  w_winIdx;
  logic        w_winVld;

  // r_armed blocks edge detection on the first clock after reset, so a line
  // already high when reset is released is not mistaken for an edge.
  assign w_lines    = 16'(irqLines);
  assign w_pendSet  = w_lines & ~r_prev & {16{r_armed}};
  assign w_ackClr   = (r_state == S_REQ && turnOffIRQ) ? (16'd1 << r_idx) : 16'd0;
  assign w_w1c      = (cfgWE && cfgAddr == 2'd1) ? (cfgData & SRC_MASK) : 16'd0;
  assign w_pendNext = ((r_pend & ~w_ackClr & ~w_w1c) | w_pendSet) & SRC_MASK;
  assign w_elig     = r_pend & r_mask & {16{r_gie}};
  assign w_winVld   = |w_elig;

  always_comb begin
    w_winIdx = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      if (w_elig[k]) w_winIdx = 4'(k);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev  <= 16'd0;
      r_pend  <= 16'd0;
      r_mask  <= 16'd0;
      r_gie   <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_prev  <= w_lines;
      r_pend  <= w_pendNext;
      r_armed <= 1'b1;
      if (cfgWE && cfgAddr == 2'd0) r_mask <= cfgData & SRC_MASK;
      if (cfgWE && cfgAddr == 2'd2) r_gie  <= cfgData[0];
    end
  end

  // Index and vector are latched on entry to REQ and stay frozen until the ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_irq     <= 1'b0;
      r_idx     <= 4'd0;
      r_intAddr <= VECTOR_BASE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_winVld) begin
            r_idx     <= w_winIdx;
            r_intAddr <= VECTOR_BASE + {26'd0, w_winIdx, 2'b00};
            r_irq     <= 1'b1;
            r_state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (turnOffIRQ) begin
            r_irq   <= 1'b0;
            r_state <= S_HOLD;
          end
        end
        S_HOLD:  r_state <= S_IDLE;
        default: begin
          r_irq   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    cfgRead = 16'd0;
    case (cfgAddr)
      2'd0: cfgRead = r_mask;
      2'd1: cfgRead = r_pend;
      2'd2: cfgRead = {15'd0, r_gie};
      2'd3: cfgRead = {(r_state != S_IDLE), 11'd0, r_idx};
      default: cfgRead = 16'd0;
    endcase
  end

  assign irq     = r_irq;
  assign intAddr = r_intAddr;
  assign intData = {12'h000, r_idx};

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: reset, single request, priority, masking,
// ack/edge collision, level-held line, GIE gating and reset during a request.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irqLines;
  logic        cfgWE;
  logic [1:0]  cfgAddr;
  logic [15:0] cfgData;
  logic [15:0] cfgRead;
  logic        irq;
  logic        turnOffIRQ;
  logic [31:0] intAddr;
  logic [15:0] intData;

  int total = 0;
  int bad   = 0;

  irq_controller #(.NUM_SRC(8), .VECTOR_BASE(32'h0000_0100)) dut (
    .clk(clk), .rst(rst), .irqLines(irqLines), .cfgWE(cfgWE), .cfgAddr(cfgAddr),
    .cfgData(cfgData), .cfgRead(cfgRead), .irq(irq), .turnOffIRQ(turnOffIRQ),
    .intAddr(intAddr), .intData(intData)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input logic [1:0] a, input logic [15:0] d);
    cfgWE = 1'b1; cfgAddr = a; cfgData = d;
    tick();
    cfgWE = 1'b0; cfgData = 16'd0;
  endtask

  task automatic cfg_rd(input logic [1:0] a, output logic [15:0] d);
    cfgAddr = a;
    #1;
    d = cfgRead;
  endtask

  task automatic ack();
    turnOffIRQ = 1'b1;
    tick();
    turnOffIRQ = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    rst = 1'b1; irqLines = 8'd0; cfgWE = 1'b0; cfgAddr = 2'd0; cfgData = 16'd0; turnOffIRQ = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%0b exp=0", irq); end
    total++; if (intAddr !== 32'h100) begin bad++; $display("FAIL reset_intAddr got=%h exp=00000100", intAddr); end
    total++; if (intData !== 16'h0) begin bad++; $display("FAIL reset_intData got=%h exp=0000", intData); end
    for (int a = 0; a < 4; a++) begin
      cfg_rd(2'(a), d);
      total++; if (d !== 16'h0) begin bad++; $display("FAIL reset_cfg%0d got=%h exp=0000", a, d); end
    end
  endtask

  task automatic test_single();
    logic [15:0] d;
    cfg_wr(2'd0, 16'h0004);
    cfg_wr(2'd2, 16'h0001);
    irqLines = 8'h04;
    tick();
    irqLines = 8'h00;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL single_early got=%0b exp=0", irq); end
    tick();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL single_irq got=%0b exp=1", irq); end
    total++; if (intAddr !== 32'h108) begin bad++; $display("FAIL single_addr got=%h exp=00000108", intAddr); end
    total++; if (intData !== 16'h0002) begin bad++; $display("FAIL single_data got=%h exp=0002", intData); end
    cfg_rd(2'd3, d);
    total++; if (d !== 16'h8002) begin bad++; $display("FAIL single_active got=%h exp=8002", d); end
    ack();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL single_ack got=%0b exp=0", irq); end
    cfg_rd(2'd1, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL single_pend got=%h exp=0000", d); end
    tick(); tick();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL single_idle got=%0b exp=0", irq); end
  endtask

  task automatic test_priority();
    logic [15:0] d;
    cfg_wr(2'd0, 16'h00FF);
    irqLines = 8'h22;
    tick();
    irqLines = 8'h00;
    tick();
    total++; if (irq !== 1'b1 || intData !== 16'h0001) begin bad++; $display("FAIL prio_first got=%0b/%h exp=1/0001", irq, intData); end
    total++; if (intAddr !== 32'h104) begin bad++; $display("FAIL prio_addr1 got=%h exp=00000104", intAddr); end
    ack();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL prio_ack got=%0b exp=0", irq); end
    tick();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL prio_hold got=%0b exp=0", irq); end
    tick();
    total++; if (irq !== 1'b1 || intData !== 16'h0005) begin bad++; $display("FAIL prio_second got=%0b/%h exp=1/0005", irq, intData); end
    total++; if (intAddr !== 32'h114) begin bad++; $display("FAIL prio_addr5 got=%h exp=00000114", intAddr); end
    ack(); tick(); tick();
    cfg_rd(2'd1, d);
    total++; if (d !== 16'h0000 || irq !== 1'b0) begin bad++; $display("FAIL prio_drain got=%h/%0b exp=0000/0", d, irq); end
  endtask

  task automatic test_masking();
    logic [15:0] d;
    cfg_wr(2'd0, 16'h0000);
    irqLines = 8'h08;
    tick();
    irqLines = 8'h00;
    tick(); tick();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL mask_noirq got=%0b exp=0", irq); end
    cfg_rd(2'd1, d);
    total++; if (d !== 16'h0008) begin bad++; $display("FAIL mask_pend got=%h exp=0008", d); end
    cfg_wr(2'd0, 16'h0008);
    tick();
    total++; if (irq !== 1'b1 || intData !== 16'h0003) begin bad++; $display("FAIL mask_enable got=%0b/%h exp=1/0003", irq, intData); end
    cfg_wr(2'd1, 16'h0008);
    tick();
    total++; if (irq !== 1'b1 || intData !== 16'h0003) begin bad++; $display("FAIL mask_w1c_req got=%0b/%h exp=1/0003", irq, intData); end
    total++; if (intAddr !== 32'h10C) begin bad++; $display("FAIL mask_addr got=%h exp=0000010c", intAddr); end
    cfg_rd(2'd1, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL mask_w1c_pend got=%h exp=0000", d); end
    ack(); tick(); tick();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL mask_done got=%0b exp=0", irq); end
  endtask

  task automatic test_collision();
    logic [15:0] d;
    cfg_wr(2'd0, 16'h00FF);
    irqLines = 8'h01;
    tick();
    irqLines = 8'h00;
    tick();
    total++; if (irq !== 1'b1 || intData !== 16'h0000) begin bad++; $display("FAIL coll_first got=%0b/%h exp=1/0000", irq, intData); end
    irqLines = 8'h01;
    ack();
    irqLines = 8'h00;
    cfg_rd(2'd1, d);
    total++; if (d !== 16'h0001) begin bad++; $display("FAIL coll_pend got=%h exp=0001", d); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL coll_c1 got=%0b exp=0", irq); end
    tick();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL coll_c2 got=%0b exp=0", irq); end
    tick();
    total++; if (irq !== 1'b1 || intData !== 16'h0000) begin bad++; $display("FAIL coll_c3 got=%0b/%h exp=1/0000", irq, intData); end
    ack(); tick(); tick();
    cfg_rd(2'd1, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL coll_drain got=%h exp=0000", d); end
  endtask

  task automatic test_level_gie();
    logic [15:0] d;
    int   reqs = 0;
    logic last = 1'b0;
    irqLines = 8'h10;
    for (int i = 0; i < 20; i++) begin
      turnOffIRQ = irq;
      tick();
      if (irq && !last) begin
        reqs++;
        total++; if (intData !== 16'h0004) begin bad++; $display("FAIL level_idx got=%h exp=0004", intData); end
      end
      last = irq;
    end
    irqLines = 8'h00; turnOffIRQ = 1'b0;
    tick(); tick(); tick();
    if (irq && !last) reqs++;
    total++; if (reqs !== 1) begin bad++; $display("FAIL level_count got=%0d exp=1", reqs); end
    cfg_wr(2'd2, 16'h0000);
    irqLines = 8'h84;
    tick();
    irqLines = 8'h00;
    tick(); tick(); tick();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL gie_off got=%0b exp=0", irq); end
    cfg_rd(2'd1, d);
    total++; if (d !== 16'h0084) begin bad++; $display("FAIL gie_pend got=%h exp=0084", d); end
    cfg_wr(2'd1, 16'hFFFF);
    cfg_rd(2'd1, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL gie_clear got=%h exp=0000", d); end
  endtask

  task automatic test_reset_midreq();
    logic [15:0] d;
    cfg_wr(2'd2, 16'h0001);
    irqLines = 8'h40;
    tick();
    irqLines = 8'h00;
    tick();
    total++; if (irq !== 1'b1 || intAddr !== 32'h118) begin bad++; $display("FAIL rstreq_pre got=%0b/%h exp=1/00000118", irq, intAddr); end
    cfgAddr = 2'd1;
    #2 rst = 1'b1;
    #1;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rstreq_irq got=%0b exp=0", irq); end
    total++; if (cfgRead !== 16'h0000) begin bad++; $display("FAIL rstreq_pend got=%h exp=0000", cfgRead); end
    total++; if (intAddr !== 32'h100 || intData !== 16'h0) begin bad++; $display("FAIL rstreq_vec got=%h/%h exp=00000100/0000", intAddr, intData); end
    irqLines = 8'h08;
    tick(); tick();
    rst = 1'b0;
    cfg_wr(2'd0, 16'h00FF);
    cfg_wr(2'd2, 16'h0001);
    tick(); tick();
    cfg_rd(2'd1, d);
    total++; if (d !== 16'h0000 || irq !== 1'b0) begin bad++; $display("FAIL rstreq_held got=%h/%0b exp=0000/0", d, irq); end
    irqLines = 8'h00;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_masking();
    test_collision();
    test_level_gie();
    test_reset_midreq();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
